jtframe_sram_arb: RTL and testbench
===================================

Name: jtframe_sram_arb

Overview:
- Controller/arbiter for the 16-bit asynchronous external SRAM on NeptUNO-class boards. That SRAM is currently tied off.
- Shares the SRAM between two requesters:
  - port 0: download/prog path (ioctl writes, RAM readback)
  - port 1: game core
- Sequences the SRAM control strobes with a programmable wait-state count.
- Sits in the board top between jtframe_mist/game instance and the SRAM_A/SRAM_Q/SRAM_WE/SRAM_OE/SRAM_UB/SRAM_LB pins. Tri-state of SRAM_Q is resolved in the top using sram_doe.

Parameters:
- AW, 21: SRAM word address width.
- WAIT, 2: cycles strobe (we_n/oe_n) held low per access; legal range 1..15.

Ports:
- clk  in  1  system clock (clk_sys domain)
- rst  in  1  synchronous reset, active-high
- p0_req  in  1  port 0 request, level
- p0_we  in  1  port 0: 1=write, 0=read
- p0_addr  in  AW  port 0 word address
- p0_din  in  16  port 0 write data
- p0_dsn  in  2  port 0 byte enables, active-low ([1]=upper)
- p0_dout  out  16  port 0 read data
- p0_rdy  out  1  port 0 access-complete pulse
- p1_req, p1_we, p1_addr, p1_din, p1_dsn, p1_dout, p1_rdy: same as port 0, for port 1
- busy  out  1  high while any access is in progress (state != IDLE)
- sram_addr  out  AW  SRAM address pins
- sram_din  in  16  SRAM data bus input
- sram_dout  out  16  SRAM data bus output
- sram_doe  out  1  drive sram_dout onto bus when 1
- sram_we_n  out  1  write strobe
- sram_oe_n  out  1  output enable
- sram_ub_n  out  1  upper byte enable
- sram_lb_n  out  1  lower byte enable

Behaviour:
- Clocking and reset:
  - Single clock clk; all outputs registered.
  - Reset is synchronous, active-high.
- Reset values:
  - state IDLE
  - sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n = 1
  - sram_doe = 0
  - sram_addr = 0, sram_dout = 0
  - p0/p1_dout = 0, p0/p1_rdy = 0, busy = 0
  - last-grant flag = 1, so port 0 wins the first tie.
- Reset mid-access: abandons the access with no rdy. Strobes are high and sram_doe is low on the cycle after rst is sampled.
- FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE:
  - Samples p0_req/p1_req.
  - Only one requesting: grant it.
  - Both requesting: grant the port not granted last (round-robin); update the last-grant flag.
  - On grant, latch addr/din/dsn/we of the granted port into sram_addr/sram_dout/byte enables; go to SETUP.
  - No request: stay in IDLE.
- SETUP (1 cycle):
  - Address and ub_n/lb_n (= latched dsn) valid.
  - we_n = oe_n = 1.
  - sram_doe = we.
- ACCESS (WAIT cycles, 4-bit down-counter):
  - Write: we_n = 0. Read: oe_n = 0.
  - Read data is captured from sram_din into the granted port's dout at the last ACCESS edge.
- HOLD (1 cycle):
  - we_n = oe_n = 1.
  - Address, byte enables and sram_doe are still held, giving write data hold time.
  - Granted port's rdy = 1 for exactly this cycle; dout is valid from this cycle until that port's next read completes.
- Return to IDLE:
  - Byte enables go high and sram_doe = 0 in IDLE.
- Latency: request sampled in IDLE at edge N -> rdy high in cycle N+WAIT+2. Every access takes WAIT+3 cycles including the IDLE cycle.
- Handshake rules:
  - Requester holds req, addr, din, dsn and we stable until its rdy.
  - Requester deasserts req at the edge where rdy=1; otherwise the still-high req is treated as a new access in the following IDLE.
  - Requests raised while busy wait; they are never lost.
- Boundary conditions:
  - Non-granted port's rdy stays 0 and its dout is unchanged.
  - dsn = 2'b11 still performs a full cycle with both byte enables high (no data effect) and still pulses rdy.
  - sram_we_n and sram_oe_n are never low simultaneously.
  - busy = (state != IDLE).

Test Plan:
- Reset then p0 write addr 0x00010, din 0xA55A, dsn 00, WAIT=2:
  - SETUP cycle, we_n low for exactly 2 cycles, doe high SETUP..HOLD.
  - p0_rdy pulses once, 4 cycles after the request edge.
- p0 read addr 0x00010 with SRAM model returning 0xA55A: oe_n low 2 cycles, p0_dout = 0xA55A in the rdy cycle, p1_dout remains 0.
- p0_req and p1_req raised in the same cycle, both held for continuous requests: grants alternate p0, p1, p0, p1; exactly one rdy per access; never both rdy in one cycle.
- Byte write dsn = 2'b10, din 0x1234 over 0xFFFF: ub_n = 1, lb_n = 0 during access; readback gives 0xFF34.
- rst asserted in the first ACCESS cycle of a write: next cycle we_n = 1, doe = 0, busy = 0, no rdy issued; a subsequent p1 read completes normally.
- WAIT=1 and WAIT=15 builds: strobe width is exactly 1 / 15 cycles; rdy latency is 3 / 17 cycles.

Source files
------------

// File: rtl/jtframe_sram_arb.sv
// jtframe_sram_arb: round-robin arbiter and strobe sequencer for a
// 16-bit asynchronous SRAM shared by a download port (p0) and the game (p1).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pN_req/we/addr/din  request level, direction, word address, write data
//   pN_dsn              byte enables, active-low ([1] = upper byte)
//   pN_dout/pN_rdy      read data (held until next read) and done pulse
//   busy                high while an access is in flight
//   sram_*              SRAM pins; sram_doe enables sram_dout onto the bus
module jtframe_sram_arb #(
    parameter int AW   = 21,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [15:0]   p0_din,
    input  logic [1:0]    p0_dsn,
    output logic [15:0]   p0_dout,
    output logic          p0_rdy,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [15:0]   p1_din,
    input  logic [1:0]    p1_dsn,
    output logic [15:0]   p1_dout,
    output logic          p1_rdy,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    input  logic [15:0]   sram_din,
    output logic [15:0]   sram_dout,
    output logic          sram_doe,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last;    // 1: port 1 won the last tie
    logic       gnt;     // port currently being served
    logic       we_l;
    logic       pick1;

    // Port 1 wins when alone, or on a tie when port 0 won the previous tie.
    assign pick1 = p1_req & (~p0_req | ~last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            gnt       <= 1'b0;
            we_l      <= 1'b0;
            busy      <= 1'b0;
            sram_addr <= '0;
            sram_dout <= '0;
            sram_doe  <= 1'b0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            p0_dout   <= '0;
            p1_dout   <= '0;
            p0_rdy    <= 1'b0;
            p1_rdy    <= 1'b0;
        end else begin
            p0_rdy <= 1'b0;
            p1_rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        gnt <= pick1;
                        if (p0_req && p1_req)
                            last <= pick1;
                        sram_addr <= pick1 ? p1_addr : p0_addr;
                        sram_dout <= pick1 ? p1_din : p0_din;
                        {sram_ub_n, sram_lb_n} <= pick1 ? p1_dsn : p0_dsn;
                        we_l     <= pick1 ? p1_we : p0_we;
                        sram_doe <= pick1 ? p1_we : p0_we;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    sram_we_n <= ~we_l;
                    sram_oe_n <= we_l;
                    cnt       <= CNT_INIT;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!we_l) begin
                            if (gnt) p1_dout <= sram_din;
                            else     p0_dout <= sram_din;
                        end
                        if (gnt) p1_rdy <= 1'b1;
                        else     p0_rdy <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_doe  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_sram_arb.sv
// tb_jtframe_sram_arb: directed checks of the SRAM arbiter with a small
// byte-enable aware SRAM model, plus WAIT=1 and WAIT=15 timing instances.
module tb_jtframe_sram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [20:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_din = '0, p1_din = '0;
    logic [1:0]  p0_dsn = '0, p1_dsn = '0;
    logic [15:0] p0_dout, p1_dout;
    logic        p0_rdy, p1_rdy, busy;
    logic [20:0] sram_addr;
    logic [15:0] sram_din, sram_dout;
    logic        sram_doe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

    int n_vec = 0;
    int n_bad = 0;
    int both_low = 0;
    int both_rdy = 0;

    always #5 clk = ~clk;

    jtframe_sram_arb #(.AW(21), .WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_din(p0_din), .p0_dsn(p0_dsn), .p0_dout(p0_dout),
        .p0_rdy(p0_rdy),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_din(p1_din), .p1_dsn(p1_dsn), .p1_dout(p1_dout),
        .p1_rdy(p1_rdy),
        .busy(busy), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout), .sram_doe(sram_doe),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // Timing-only instances with different wait-state counts.
    logic [1:0]  xreq = '0, xwe = '0;
    logic [1:0]  x_we_n, x_oe_n, x_rdy, x_busy, x_rdy1, x_doe;
    logic [1:0]  x_ub, x_lb;
    logic [15:0] x_d0a, x_d1a, x_sd_a, x_d0b, x_d1b, x_sd_b;
    logic [20:0] x_ad_a, x_ad_b;

    jtframe_sram_arb #(.AW(21), .WAIT(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .p0_req(xreq[0]), .p0_we(xwe[0]), .p0_addr(21'h5),
        .p0_din(16'h1111), .p0_dsn(2'b00), .p0_dout(x_d0a),
        .p0_rdy(x_rdy[0]),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(21'h0),
        .p1_din(16'h0), .p1_dsn(2'b00), .p1_dout(x_d1a),
        .p1_rdy(x_rdy1[0]),
        .busy(x_busy[0]), .sram_addr(x_ad_a), .sram_din(16'h0),
        .sram_dout(x_sd_a), .sram_doe(x_doe[0]),
        .sram_we_n(x_we_n[0]), .sram_oe_n(x_oe_n[0]),
        .sram_ub_n(x_ub[0]), .sram_lb_n(x_lb[0])
    );

    jtframe_sram_arb #(.AW(21), .WAIT(15)) dut_w15 (
        .clk(clk), .rst(rst),
        .p0_req(xreq[1]), .p0_we(xwe[1]), .p0_addr(21'h6),
        .p0_din(16'h2222), .p0_dsn(2'b00), .p0_dout(x_d0b),
        .p0_rdy(x_rdy[1]),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(21'h0),
        .p1_din(16'h0), .p1_dsn(2'b00), .p1_dout(x_d1b),
        .p1_rdy(x_rdy1[1]),
        .busy(x_busy[1]), .sram_addr(x_ad_b), .sram_din(16'h0),
        .sram_dout(x_sd_b), .sram_doe(x_doe[1]),
        .sram_we_n(x_we_n[1]), .sram_oe_n(x_oe_n[1]),
        .sram_ub_n(x_ub[1]), .sram_lb_n(x_lb[1])
    );

    // SRAM model: byte-masked write while we_n is low, async read on oe_n.
    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        if (!sram_we_n && sram_doe) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dout[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dout[7:0];
        end
    end

    always_comb begin
        sram_din = 16'hDEAD;
        if (!sram_oe_n) sram_din = mem[sram_addr[7:0]];
    end

    always @(negedge clk) begin
        if (!sram_we_n && !sram_oe_n) both_low++;
        for (int i = 0; i < 2; i++)
            if (!x_we_n[i] && !x_oe_n[i]) both_low++;
        if (p0_rdy && p1_rdy) both_rdy++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    endtask

    task automatic acc(input int port, input bit we,
                       input logic [20:0] addr, input logic [15:0] din,
                       input logic [1:0] dsn,
                       output int lat, output int wlow, output int olow,
                       output int doe_c, output int other,
                       output logic [1:0] be, output logic [15:0] dout);
        bit done = 0;
        lat = 0; wlow = 0; olow = 0; doe_c = 0; other = 0;
        be = 2'bxx; dout = 'x;
        wait_idle();
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_din = din; p0_dsn = dsn;
            p0_req = 1;
        end else begin
            p1_we = we; p1_addr = addr; p1_din = din; p1_dsn = dsn;
            p1_req = 1;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            lat++;
            if (!sram_we_n) wlow++;
            if (!sram_oe_n) olow++;
            if (!sram_we_n || !sram_oe_n) be = {sram_ub_n, sram_lb_n};
            if (sram_doe) doe_c++;
            if (port == 0 ? p1_rdy : p0_rdy) other++;
            if (port == 0 ? p0_rdy : p1_rdy) begin
                dout = (port == 0) ? p0_dout : p1_dout;
                done = 1;
                break;
            end
        end
        p0_req = 0;
        p1_req = 0;
        if (!done) chk("acc_timeout", 0, 1);
    endtask

    task automatic xacc(input int i, input bit we,
                        output int lat, output int width);
        bit done = 0;
        lat = 0; width = 0;
        for (int k = 0; k < 50 && x_busy[i]; k++) @(negedge clk);
        xwe[i] = we;
        xreq[i] = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            lat++;
            if (!x_we_n[i] || !x_oe_n[i]) width++;
            if (x_rdy[i]) begin
                done = 1;
                break;
            end
        end
        xreq[i] = 0;
        if (!done) chk("xacc_timeout", 0, 1);
    endtask

    int lat, wl, ol, dc, oth, cnt, nr, lastc;
    logic [1:0]  be;
    logic [15:0] d;
    int seq [4];
    int gap [4];

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_strobes", {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 4'hF);
        chk("rst_doe_busy_rdy", {sram_doe, busy, p0_rdy, p1_rdy}, 4'h0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_douts", {p0_dout, p1_dout}, 0);
        chk("rst_sram_dout", sram_dout, 0);
        rst = 0;
        @(negedge clk);

        acc(0, 1, 21'h10, 16'hA55A, 2'b00, lat, wl, ol, dc, oth, be, d);
        chk("wr_latency", lat, 4);
        chk("wr_we_width", wl, 2);
        chk("wr_oe_width", ol, 0);
        chk("wr_doe_cycles", dc, 4);
        chk("wr_be", be, 2'b00);
        chk("wr_other_rdy", oth, 0);
        @(negedge clk);
        chk("wr_rdy_single", {p0_rdy, busy, sram_doe}, 3'b000);
        chk("wr_be_idle", {sram_ub_n, sram_lb_n}, 2'b11);

        acc(0, 0, 21'h10, 16'h0, 2'b00, lat, wl, ol, dc, oth, be, d);
        chk("rd_latency", lat, 4);
        chk("rd_oe_width", ol, 2);
        chk("rd_we_width", wl, 0);
        chk("rd_doe_cycles", dc, 0);
        chk("rd_data", d, 16'hA55A);
        chk("rd_p1_dout", p1_dout, 0);

        // Both ports request together and keep requesting.
        wait_idle();
        p0_we = 0; p0_addr = 21'h10; p0_dsn = 2'b00;
        p1_we = 0; p1_addr = 21'h10; p1_dsn = 2'b00;
        p0_req = 1; p1_req = 1;
        cnt = 0; nr = 0; lastc = 0;
        for (int k = 0; k < 60 && nr < 4; k++) begin
            @(negedge clk);
            cnt++;
            if (p0_rdy || p1_rdy) begin
                seq[nr] = p1_rdy ? 1 : 0;
                gap[nr] = cnt - lastc;
                lastc = cnt;
                nr++;
                if (nr == 4) begin
                    p0_req = 0;
                    p1_req = 0;
                end
            end
        end
        p0_req = 0; p1_req = 0;
        chk("rr_count", nr, 4);
        chk("rr_seq", {seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]},
            8'b00_01_00_01);
        chk("rr_first_lat", gap[0], 4);
        chk("rr_gap", {gap[1][7:0], gap[2][7:0], gap[3][7:0]}, 24'h050505);
        chk("rr_douts", {p0_dout, p1_dout}, {16'hA55A, 16'hA55A});

        acc(0, 1, 21'h40, 16'hFFFF, 2'b00, lat, wl, ol, dc, oth, be, d);
        acc(0, 1, 21'h40, 16'h1234, 2'b10, lat, wl, ol, dc, oth, be, d);
        chk("bw_be", be, 2'b10);
        acc(0, 0, 21'h40, 16'h0, 2'b00, lat, wl, ol, dc, oth, be, d);
        chk("bw_readback", d, 16'hFF34);

        acc(0, 1, 21'h40, 16'h0000, 2'b11, lat, wl, ol, dc, oth, be, d);
        chk("dsn11_latency", lat, 4);
        chk("dsn11_be", be, 2'b11);
        acc(1, 0, 21'h40, 16'h0, 2'b00, lat, wl, ol, dc, oth, be, d);
        chk("dsn11_readback", d, 16'hFF34);
        chk("p1_rd_other_rdy", oth, 0);
        chk("p1_rd_p0_dout", p0_dout, 16'hFF34);

        // Reset in the first ACCESS cycle of a write.
        wait_idle();
        p0_we = 1; p0_addr = 21'h80; p0_din = 16'h5555; p0_dsn = 2'b00;
        p0_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pre_we", sram_we_n, 0);
        rst = 1;
        p0_req = 0;
        @(negedge clk);
        chk("rst_mid_post", {sram_we_n, sram_doe, busy, p0_rdy}, 4'b1000);
        chk("rst_mid_douts", {p0_dout, p1_dout}, 0);
        rst = 0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (p0_rdy || p1_rdy) cnt++;
        end
        chk("rst_mid_no_rdy", cnt, 0);
        acc(1, 0, 21'h10, 16'h0, 2'b00, lat, wl, ol, dc, oth, be, d);
        chk("post_rst_p1_lat", lat, 4);
        chk("post_rst_p1_data", d, 16'hA55A);
        chk("post_rst_p0_dout", p0_dout, 0);

        xacc(0, 1, lat, wl);
        chk("w1_wr_lat", lat, 3);
        chk("w1_wr_width", wl, 1);
        xacc(0, 0, lat, wl);
        chk("w1_rd_lat", lat, 3);
        chk("w1_rd_width", wl, 1);
        xacc(1, 1, lat, wl);
        chk("w15_wr_lat", lat, 17);
        chk("w15_wr_width", wl, 15);
        xacc(1, 0, lat, wl);
        chk("w15_rd_lat", lat, 17);
        chk("w15_rd_width", wl, 15);

        chk("never_both_strobes", both_low, 0);
        chk("never_both_rdy", both_rdy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
